// File: rtl/timer_dev.sv
// timer_dev: memory-mapped 32-bit down-counting timer with one-shot and periodic
// modes and a maskable interrupt, exposed as CTRL / PRESET / COUNT word registers.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  DEV_Addr,
    input  logic [31:0] DEV_WD,
    input  logic        WeDEV2,
    output logic [31:0] DEV2_RD,
    output logic        IRQ
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_PERIOD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_enable;
    logic [1:0]  r_mode;
    logic        r_im;
    logic        r_irq_pending;
    logic        r_irq;
    logic [31:0] r_preset;
    logic [31:0] r_count;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_periodic;
    logic        w_run;
    logic        w_enter_int;
    logic        w_enable_nxt;
    logic        w_im_nxt;
    logic        w_pending_nxt;
    logic [31:0] w_count_nxt;

    assign w_wr_ctrl   = WeDEV2 && (DEV_Addr == ADDR_CTRL);
    assign w_wr_preset = WeDEV2 && (DEV_Addr == ADDR_PRESET);
    assign w_periodic  = (r_mode == MODE_PERIOD);

    // A CTRL write that clears Enable stops the FSM on the same edge it lands.
    assign w_run = r_enable && !(w_wr_ctrl && !DEV_WD[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_run) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!w_run) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt = r_preset;
                    w_state_nxt = S_CNT;
                end
            end
            S_CNT: begin
                if (!w_run) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // Covers both COUNT==1 and a zero PRESET; never wraps.
                    w_count_nxt = 32'd0;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (w_run && w_periodic) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_enter_int = (w_state_nxt == S_INT) && (r_state != S_INT);

    always_comb begin
        w_enable_nxt = r_enable;
        if (w_wr_ctrl) begin
            w_enable_nxt = DEV_WD[0];
        end else if ((r_state == S_INT) && !w_periodic) begin
            w_enable_nxt = 1'b0;
        end
    end

    assign w_im_nxt = w_wr_ctrl ? DEV_WD[3] : r_im;

    // Setting the pending flag outranks every clearing source.
    always_comb begin
        w_pending_nxt = r_irq_pending;
        if (w_enter_int) begin
            w_pending_nxt = 1'b1;
        end else if (w_wr_ctrl) begin
            w_pending_nxt = 1'b0;
        end else if ((r_state == S_INT) && w_periodic) begin
            w_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable      <= 1'b0;
            r_mode        <= 2'b00;
            r_im          <= 1'b0;
            r_preset      <= 32'd0;
            r_count       <= 32'd0;
            r_irq_pending <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_enable      <= w_enable_nxt;
            r_im          <= w_im_nxt;
            r_count       <= w_count_nxt;
            r_irq_pending <= w_pending_nxt;
            // IRQ comes straight from a flop so the bridge never sees a glitch.
            r_irq         <= w_pending_nxt && w_im_nxt;
            if (w_wr_ctrl) begin
                r_mode <= DEV_WD[2:1];
            end
            if (w_wr_preset) begin
                r_preset <= DEV_WD;
            end
        end
    end

    assign IRQ = r_irq;

    always_comb begin
        DEV2_RD = 32'd0;
        case (DEV_Addr)
            ADDR_CTRL:   DEV2_RD = {28'd0, r_im, r_mode, r_enable};
            ADDR_PRESET: DEV2_RD = r_preset;
            ADDR_COUNT:  DEV2_RD = r_count;
            default:     DEV2_RD = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev: register access, one-shot, periodic,
// zero preset, masked interrupt, freeze/reload, write priority and mid-count reset.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  DEV_Addr;
    logic [31:0] DEV_WD;
    logic        WeDEV2;
    logic [31:0] DEV2_RD;
    logic        IRQ;

    int n_total;
    int n_pass;

    timer_dev dut (
        .clk      (clk),
        .reset    (reset),
        .DEV_Addr (DEV_Addr),
        .DEV_WD   (DEV_WD),
        .WeDEV2   (WeDEV2),
        .DEV2_RD  (DEV2_RD),
        .IRQ      (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        DEV_Addr = addr;
        DEV_WD   = data;
        WeDEV2   = 1'b1;
        step();
        WeDEV2   = 1'b0;
        DEV_WD   = 32'd0;
    endtask

    task automatic rd(input logic [1:0] addr, input string tag, input logic [31:0] exp);
        DEV_Addr = addr;
        #1;
        chk(tag, DEV2_RD, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        reset    = 1'b0;
        DEV_Addr = 2'd0;
        DEV_WD   = 32'd0;
        WeDEV2   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rd(2'd0, "rst_ctrl", 32'h0);
        rd(2'd1, "rst_preset", 32'h0);
        rd(2'd2, "rst_count", 32'h0);
        rd(2'd3, "rst_idx3", 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b1;
        step();

        // One-shot, PRESET=3, IM=1
        wr(2'd1, 32'd3);
        rd(2'd1, "os_preset", 32'd3);
        wr(2'd0, 32'h9);
        rd(2'd0, "os_ctrl", 32'h9);
        step();                                   // LOAD
        rd(2'd2, "os_load_cnt", 32'd0);
        step();
        rd(2'd2, "os_cnt3", 32'd3);
        chk_irq("os_irq_early", 1'b0);
        step();
        rd(2'd2, "os_cnt2", 32'd2);
        step();
        rd(2'd2, "os_cnt1", 32'd1);
        chk_irq("os_irq_cnt1", 1'b0);
        step();                                   // INT
        rd(2'd2, "os_cnt0", 32'd0);
        chk_irq("os_irq_set", 1'b1);
        step();                                   // back to IDLE, Enable cleared
        rd(2'd0, "os_ctrl_after", 32'h8);
        chk_irq("os_irq_hold1", 1'b1);
        step();
        chk_irq("os_irq_hold2", 1'b1);
        rd(2'd2, "os_cnt_hold", 32'd0);
        wr(2'd0, 32'h8);
        chk_irq("os_irq_clr", 1'b0);

        // Periodic, PRESET=2, IM=1: pulse on every fourth edge
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_irq($sformatf("per_irq_e%0d", k), (k % 4) == 0);
        end
        rd(2'd0, "per_ctrl", 32'hB);
        wr(2'd0, 32'h8);
        chk_irq("per_stop_irq", 1'b0);
        step();
        chk_irq("per_idle_irq", 1'b0);

        // Zero preset: LOAD, CNT, then INT
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step();
        step();
        chk_irq("z_irq_cnt", 1'b0);
        step();
        chk_irq("z_irq_int", 1'b1);
        rd(2'd2, "z_count", 32'd0);
        wr(2'd0, 32'h8);
        chk_irq("z_irq_clr", 1'b0);

        // Masked expiry, then unmasking CTRL write must not expose stale pending
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        step();
        step();
        step();
        step();                                   // INT
        chk_irq("m_irq_int", 1'b0);
        rd(2'd2, "m_count", 32'd0);
        step();
        rd(2'd0, "m_ctrl", 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("m_irq_w", 1'b0);
        step();
        chk_irq("m_irq_w2", 1'b0);

        // Mid-count PRESET write and disable freeze, then reload
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step();
        step();
        rd(2'd2, "f_cnt5", 32'd5);
        step();
        rd(2'd2, "f_cnt4", 32'd4);
        wr(2'd1, 32'h10);
        rd(2'd2, "f_cnt_pw", 32'd3);
        wr(2'd0, 32'h8);
        rd(2'd2, "f_cnt_frz", 32'd3);
        step();
        step();
        rd(2'd2, "f_cnt_frz2", 32'd3);
        rd(2'd1, "f_preset", 32'h10);
        wr(2'd0, 32'h9);
        step();
        rd(2'd2, "f_load_pend", 32'd3);
        step();
        rd(2'd2, "f_reload", 32'h10);
        wr(2'd0, 32'h0);
        rd(2'd2, "f_stop", 32'h10);

        // Ignored writes and read-zero fields
        wr(2'd2, 32'hDEADBEEF);
        rd(2'd2, "ro_count", 32'h10);
        wr(2'd3, 32'hFFFFFFFF);
        rd(2'd3, "ro_idx3", 32'h0);
        wr(2'd0, 32'hFFFFFFF8);
        rd(2'd0, "ro_ctrl_hi", 32'h8);
        step();
        step();
        rd(2'd2, "ro_count_idle", 32'h10);

        // Set beats a CTRL write on the INT entry edge; written Enable beats HW clear
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        step();                                   // LOAD
        step();                                   // CNT, COUNT=1
        rd(2'd2, "p_cnt1", 32'd1);
        wr(2'd0, 32'h9);                          // lands on the INT entry edge
        chk_irq("p_set_wins", 1'b1);
        wr(2'd0, 32'h9);                          // lands on the INT exit edge
        rd(2'd0, "p_en_wins", 32'h9);
        chk_irq("p_clr", 1'b0);
        step();                                   // LOAD again
        step();
        rd(2'd2, "p_rerun", 32'd1);

        // Reset asserted mid-count
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        step();
        step();
        step();
        rd(2'd2, "r_running", 32'd19);
        reset = 1'b0;
        #1;
        rd(2'd2, "r_count0", 32'h0);
        rd(2'd1, "r_preset0", 32'h0);
        rd(2'd0, "r_ctrl0", 32'h0);
        chk_irq("r_irq0", 1'b0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk_irq("r_after_irq", 1'b0);
        end
        rd(2'd2, "r_after_cnt", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameters: none; register map and widths are fixed.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 DEV_Addr  input  2  word index within device window (0x7F00 base): 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-005 DEV_WD  input  32  write data from bridge, full word, no byte enables.
REQ-006 WeDEV2  input  1  write strobe, already qualified by bridge address hit.
REQ-007 DEV2_RD  output  32  read data for selected register, combinational from DEV_Addr.
REQ-008 IRQ  output  1  interrupt request to bridge (becomes HWInt[0]).

Function
REQ-009 CTRL layout SHALL be: bit0 Enable, bits[2:1] Mode (00 one-shot, 01 periodic, 1x treated as one-shot), bit3 IM (interrupt mask, 1 = IRQ enabled), bits[31:4] read 0, writes ignored.
REQ-010 PRESET SHALL be a 32-bit read/write reload value; COUNT SHALL be a 32-bit read-only down-counter; writes to COUNT and to index 3 SHALL be ignored; index 3 SHALL read 0.
REQ-011 Register writes SHALL take effect on the rising edge where WeDEV2=1; DEV2_RD SHALL reflect the new value from the following cycle.
REQ-012 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-013 IDLE: COUNT holds; Enable=1 -> LOAD on next edge.
REQ-014 LOAD: COUNT <= PRESET; -> CNT.
REQ-015 CNT: Enable=0 -> IDLE, COUNT holds; else COUNT>1 -> COUNT-1, stay; COUNT==1 -> COUNT <= 0, -> INT; COUNT==0 (PRESET was 0) -> INT, COUNT stays 0.
REQ-016 Entering INT SHALL set irq_pending on that same edge.
REQ-017 INT, one-shot mode: Enable cleared by hardware, -> IDLE; irq_pending stays set until any CTRL write.
REQ-018 INT, periodic mode: -> LOAD; irq_pending cleared on edge leaving INT (exactly one-cycle pulse).
REQ-019 IRQ SHALL equal irq_pending AND IM; IRQ SHALL be driven from registered state, glitch-free.
REQ-020 Any CTRL write SHALL clear irq_pending, except on an edge where FSM enters INT: set wins.
REQ-021 CTRL write on same edge as INT hardware clears Enable: written Enable value wins.
REQ-022 PRESET write during CNT SHALL NOT alter COUNT; takes effect at next LOAD.
REQ-023 Writing Enable=0 in any state SHALL return FSM to IDLE within one edge (LOAD/CNT/INT -> IDLE), COUNT holding its value.
REQ-024 COUNT SHALL never wrap below 0.

Reset
REQ-025 While reset=0: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_pending=0, IRQ=0, DEV2_RD per DEV_Addr over zeroed registers.
REQ-026 Reset deassertion mid-count SHALL restart from IDLE with all registers zero; no IRQ emitted.

Verification
REQ-027 Reset, read idx 0/1/2/3 -> all 0x00000000, IRQ=0.
REQ-028 PRESET=3, CTRL=0x9 (one-shot, IM=1) -> COUNT reads 3,2,1,0 on consecutive cycles after LOAD; IRQ=1 on edge COUNT hits 0; CTRL reads 0x8; IRQ held until CTRL write 0x8 -> IRQ=0 next cycle.
REQ-029 PRESET=2, CTRL=0xB (periodic, IM=1) -> IRQ one-cycle pulse every 4 cycles (LOAD,2,1->INT) repeated, Enable stays 1.
REQ-030 PRESET=0, CTRL=0x9 -> INT two edges after enable (LOAD, CNT), IRQ=1, COUNT=0.
REQ-031 CTRL=0x1 (IM=0) count expiry -> IRQ stays 0; subsequent write CTRL=0x8 -> IRQ stays 0 (pending cleared by write).
REQ-032 Mid-count PRESET=0x10 write then Enable=0 write -> COUNT unchanged and frozen, FSM IDLE; re-enable -> COUNT loads 0x10.
